// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types, parity modes and timing helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit; clk_fre is given in MHz, rate in bit/s.
  function automatic int bit_cycles(input int clk_fre, input int rate);
    return (clk_fre * 1_000_000) / rate;
  endfunction

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : bit-period counter with restart and one-cycle end tick
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int CYCLES = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : UART transmitter with one-entry holding register for gapless frames
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       send_ready,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int BIT_CYC = bit_cycles(CLK_FRE, UART_RATE);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  state, state_next;
  logic [7:0] shift, hold;
  logic       hold_full, par_bit;
  logic [2:0] bit_cnt;
  logic       tick, tx_next;
  logic       accept, stop_end, load_new, load_hold;

  assign accept     = send_en && send_ready;
  assign stop_end   = (state == S_STOP) && tick && (bit_cnt == LAST_STOP);
  // A byte offered on the final stop cycle with nothing held skips the hold.
  assign load_new   = accept && ((state == S_IDLE) || (stop_end && !hold_full));
  assign load_hold  = stop_end && hold_full;
  assign send_ready = !hold_full;
  assign tx_busy    = (state != S_IDLE) || hold_full;

  uart_baud_tick #(
    .CYCLES (BIT_CYC)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state == S_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      tx_pin <= 1'b1;
    end else begin
      state  <= state_next;
      tx_pin <= tx_next;
    end
  end

  // tx_next is the line level for the cycle after this edge, so the pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_START;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        tx_next = 1'b0;
        if (tick) begin
          state_next = S_DATA;
          tx_next    = shift[0];
        end
      end
      S_DATA: begin
        tx_next = shift[0];
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              state_next = S_PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next = shift[1];
          end
        end
      end
      S_PARITY: begin
        tx_next = par_bit;
        if (tick) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        tx_next = 1'b1;
        if (stop_end) begin
          if (hold_full || accept) begin
            state_next = S_START;
            tx_next    = 1'b0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      if (load_new) begin
        shift   <= send_data;
        par_bit <= parity_bit(send_data, PARITY);
      end else if (load_hold) begin
        shift   <= hold;
        par_bit <= parity_bit(hold, PARITY);
      end else if (state == S_DATA && tick) begin
        shift <= {1'b0, shift[7:1]};
      end

      if (load_hold) begin
        hold_full <= 1'b0;
      end
      if (accept && !load_new) begin
        hold      <= send_data;
        hold_full <= 1'b1;
      end

      // Counts data bits and stop bits; restarts whenever the state changes.
      if (tick) begin
        if (state_next != state) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
